// File: rtl/outarb.sv
// Round-robin switch arbiter for one physical output channel.
// Locks each virtual channel to one input port from head grant to tail grant.
module outarb #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int NREQ     = 5,
    parameter int IDW      = 3
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [NREQ-1:0] ireq,
    input  logic [NREQ-1:0] ivch,
    input  logic [NREQ-1:0] ihead,
    input  logic [NREQ-1:0] itail,
    input  logic [1:0]      ivrdy,
    output logic [NREQ-1:0] ogrant,
    output logic            ogvalid,
    output logic            ogvch,
    output logic [IDW-1:0]  ogid,
    output logic [1:0]      ovbusy,
    output logic            oerr
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ ||
        ROUTERID < 0 || PCHID < 0) begin : g_bad_param
        $error("outarb: illegal parameter combination");
    end

    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [1:0]           own_v_q, own_v_d;
    logic [1:0][IDW-1:0]  owner_q, owner_d;
    logic                 err_q, err_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            bad;
    logic            found;
    logic            gnt_vch;
    logic            gnt_head;
    logic            gnt_tail;
    logic [IDW-1:0]  gnt_id;

    // Body/tail flits rely on space reserved when their head was admitted.
    always_comb begin
        elig = '0;
        bad  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (ireq[i]) begin
                if (ihead[i]) begin
                    elig[i] = !own_v_q[ivch[i]] && ivrdy[ivch[i]];
                end else if (own_v_q[ivch[i]] &&
                             owner_q[ivch[i]] == IDW'(i)) begin
                    elig[i] = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
        end
    end

    // Two passes: indices at/after ptr first, then the wrapped-around ones.
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        gnt_id   = '0;
        gnt_vch  = 1'b0;
        gnt_head = 1'b0;
        gnt_tail = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rst_ && !found && elig[i] && IDW'(i) >= ptr_q) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                gnt_id   = IDW'(i);
                gnt_vch  = ivch[i];
                gnt_head = ihead[i];
                gnt_tail = itail[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rst_ && !found && elig[i] && IDW'(i) < ptr_q) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                gnt_id   = IDW'(i);
                gnt_vch  = ivch[i];
                gnt_head = ihead[i];
                gnt_tail = itail[i];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        own_v_d = own_v_q;
        owner_d = owner_q;
        err_d   = err_q | bad;
        if (found) begin
            if (gnt_id == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + IDW'(1);
            end
            if (gnt_head && !gnt_tail) begin
                own_v_d[gnt_vch] = 1'b1;
                owner_d[gnt_vch] = gnt_id;
            end else if (!gnt_head && gnt_tail) begin
                own_v_d[gnt_vch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            ptr_q   <= '0;
            own_v_q <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            own_v_q <= own_v_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign ogrant  = gnt;
    assign ogvalid = found;
    assign ogvch   = gnt_vch;
    assign ogid    = gnt_id;
    assign ovbusy  = own_v_q;
    assign oerr    = err_q;

endmodule

// File: tb/tb_outarb.sv
// Bench for outarb: spec-level model checked every cycle plus directed
// vectors with hand-computed grants.
module tb_outarb;

    localparam int NREQ = 5;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            rst_;
    logic [NREQ-1:0] ireq, ivch, ihead, itail;
    logic [1:0]      ivrdy;
    logic [NREQ-1:0] ogrant;
    logic            ogvalid, ogvch, oerr;
    logic [IDW-1:0]  ogid;
    logic [1:0]      ovbusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    outarb #(.ROUTERID(0), .PCHID(0), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_(rst_),
        .ireq(ireq), .ivch(ivch), .ihead(ihead), .itail(itail),
        .ivrdy(ivrdy),
        .ogrant(ogrant), .ogvalid(ogvalid), .ogvch(ogvch), .ogid(ogid),
        .ovbusy(ovbusy), .oerr(oerr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: owner of each VC (-1 = free), round-robin start, sticky error.
    int m_own [2];
    int m_ptr   = 0;
    bit m_err   = 1'b0;
    bit started = 1'b0;
    int e_k     = -1;
    bit e_bad   = 1'b0;

    initial begin
        m_own[0] = -1;
        m_own[1] = -1;
    end

    function automatic bit eligible(input int k);
        int v;
        v = int'(ivch[k]);
        if (!ireq[k]) return 1'b0;
        if (ihead[k]) return (m_own[v] < 0) && ivrdy[v];
        return m_own[v] == k;
    endfunction

    function automatic int winner();
        for (int n = 0; n < NREQ; n++) begin
            if (eligible((m_ptr + n) % NREQ)) return (m_ptr + n) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            e_k   = -1;
            e_bad = 1'b0;
            if (rst_) begin
                e_k = winner();
                for (int i = 0; i < NREQ; i++) begin
                    if (ireq[i] && !ihead[i] && m_own[int'(ivch[i])] != i)
                        e_bad = 1'b1;
                end
            end
            chk("m_grant", ogrant, (e_k < 0) ? 0 : (1 << e_k));
            chk("m_valid", ogvalid, e_k >= 0);
            chk("m_vch", ogvch, (e_k < 0) ? 0 : ivch[e_k]);
            chk("m_id", ogid, (e_k < 0) ? 0 : e_k);
            chk("m_busy", ovbusy, {m_own[1] >= 0, m_own[0] >= 0});
            chk("m_err", oerr, m_err);
        end
    end

    always @(posedge clk) begin
        if (!rst_) begin
            m_ptr    = 0;
            m_own[0] = -1;
            m_own[1] = -1;
            m_err    = 1'b0;
        end else if (started) begin
            if (e_k >= 0) begin
                m_ptr = (e_k + 1) % NREQ;
                if (ihead[e_k] && !itail[e_k])
                    m_own[int'(ivch[e_k])] = e_k;
                else if (!ihead[e_k] && itail[e_k])
                    m_own[int'(ivch[e_k])] = -1;
            end
            if (e_bad) m_err = 1'b1;
        end
        started = 1'b1;
    end

    task automatic cyc(input logic r, input logic [NREQ-1:0] q,
                       input logic [NREQ-1:0] v, input logic [NREQ-1:0] h,
                       input logic [NREQ-1:0] t, input logic [1:0] rdy);
        @(posedge clk);
        #1;
        rst_  = r;
        ireq  = q;
        ivch  = v;
        ihead = h;
        itail = t;
        ivrdy = rdy;
        @(negedge clk);
        #1;
    endtask

    logic [NREQ-1:0] rr_exp [5];

    initial begin
        rr_exp = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100};
        rst_  = 1'b0;
        ireq  = '1;
        ivch  = '0;
        ihead = '1;
        itail = '1;
        ivrdy = 2'b11;

        cyc(0, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b11);
        chk("rst_grant0", ogrant, 0);
        chk("rst_busy", ovbusy, 0);
        chk("rst_err", oerr, 0);
        cyc(0, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b11);
        chk("rst_grant1", ogrant, 0);
        chk("rst_valid", ogvalid, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 5'b10101, 5'b00000, 5'b10101, 5'b10101, 2'b11);
            chk("rr_order", ogrant, rr_exp[i]);
        end
        cyc(1, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 2'b11);
        chk("rr_wrap", ogrant, 5'b00001);

        cyc(1, 5'b01010, 5'b01010, 5'b01010, 5'b00000, 2'b11);
        chk("lock_head", ogrant, 5'b00010);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 5'b01010, 5'b01010, 5'b01000, 5'b00000, 2'b11);
            chk("lock_body", ogrant, 5'b00010);
            chk("lock_busy", ovbusy, 2'b10);
        end
        cyc(1, 5'b01010, 5'b01010, 5'b01000, 5'b00010, 2'b11);
        chk("lock_tail", ogrant, 5'b00010);
        chk("lock_busy_t", ovbusy, 2'b10);
        cyc(1, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 2'b11);
        chk("lock_next", ogrant, 5'b01000);
        chk("lock_free", ovbusy, 2'b00);

        cyc(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 2'b11);
        chk("ind_vc0", ogrant, 5'b00001);
        cyc(1, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 2'b11);
        chk("ind_vc1", ogrant, 5'b00100);
        chk("ind_vch", ogvch, 1);
        chk("ind_id", ogid, 2);
        cyc(1, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 2'b11);
        chk("ind_busy", ovbusy, 2'b11);
        chk("ind_tail", ogrant, 5'b00100);

        cyc(1, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 2'b01);
        chk("cred_block", ogrant, 0);
        chk("cred_valid", ogvalid, 0);
        cyc(1, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 2'b11);
        chk("cred_go", ogrant, 5'b10000);
        chk("cred_id", ogid, 4);
        cyc(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 2'b10);
        chk("cred_body", ogrant, 5'b00001);
        cyc(1, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 2'b00);
        chk("cred_tail", ogrant, 5'b00001);

        cyc(1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b11);
        chk("err_nogrant", ogrant, 0);
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
        chk("err_set", oerr, 1);
        cyc(1, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 2'b11);
        chk("err_lock", ogrant, 5'b00010);
        cyc(1, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b11);
        chk("err_other", ogrant, 0);
        chk("err_sticky", oerr, 1);
        chk("err_busy", ovbusy, 2'b10);
        cyc(0, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 2'b11);
        chk("mid_rst_grant", ogrant, 0);
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
        chk("mid_rst_busy", ovbusy, 0);
        chk("mid_rst_err", oerr, 0);

        cyc(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
